// File: rtl/sp_if_ddr_arb.sv
// Round-robin arbiter that muxes NUM_REQ DDR command requesters onto one DDR controller port.
// Optional ISSUE watchdog is enabled with `define SP_IF_DDR_ARB_TIMEOUT_EN.
module sp_if_ddr_arb #(
  parameter int          NUM_REQ     = 4,
  parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
) (
  input  logic                  i_clk156m,
  input  logic                  i_arst_n,
  input  logic [NUM_REQ-1:0]    i_req_start,
  input  logic [NUM_REQ-1:0]    i_req_wxr,
  input  logic [4*NUM_REQ-1:0]  i_req_area,
  input  logic [27*NUM_REQ-1:0] i_req_addr,
  input  logic [32*NUM_REQ-1:0] i_req_size,
  input  logic                  i_ddr_endp,
  output logic                  o_ddr_wxr,
  output logic [3:0]            o_ddr_area,
  output logic [26:0]           o_ddr_addr,
  output logic [31:0]           o_ddr_size,
  output logic                  o_ddr_start,
  output logic [NUM_REQ-1:0]    o_req_endp,
  output logic [NUM_REQ-1:0]    o_grant,
  output logic                  o_busy,
  output logic                  o_drop_evt,
  output logic [2:0]            o_state
);

  localparam int LG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: a requester holds i_req_start until it sees its o_req_endp pulse;
  // the DDR side holds o_ddr_start until one i_ddr_endp pulse arrives in ISSUE.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_ISSUE = 3'd2,
    S_DONE  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t            state;
  logic [LG_W-1:0]   last_grant;
  logic [LG_W-1:0]   owner;
  logic              drop_q;
  logic              win_found;
  logic [LG_W-1:0]   win_idx;
  int                cand;
  logic [3:0]        area_arr [NUM_REQ];
  logic [26:0]       addr_arr [NUM_REQ];
  logic [31:0]       size_arr [NUM_REQ];
  logic              tmo_hit;

  assign o_state = state;

  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      area_arr[r] = i_req_area[r*4 +: 4];
      addr_arr[r] = i_req_addr[r*27 +: 27];
      size_arr[r] = i_req_size[r*32 +: 32];
    end
  end

  // Walk from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = int'(last_grant) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (i_req_start[LG_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = LG_W'(cand);
      end
    end
  end

`ifdef SP_IF_DDR_ARB_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  always_ff @(posedge i_clk156m or negedge i_arst_n) begin
    if (!i_arst_n)              tmo_cnt <= '0;
    else if (state == S_ISSUE)  tmo_cnt <= tmo_cnt + 32'd1;
    else                        tmo_cnt <= '0;
  end

  assign tmo_hit = (state == S_ISSUE) && (tmo_cnt == TIMEOUT_CYC - 32'd1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge i_clk156m or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state       <= S_IDLE;
      last_grant  <= LG_W'(NUM_REQ - 1);
      owner       <= '0;
      drop_q      <= 1'b0;
      o_ddr_start <= 1'b0;
      o_ddr_wxr   <= 1'b0;
      o_ddr_area  <= '0;
      o_ddr_addr  <= '0;
      o_ddr_size  <= '0;
      o_req_endp  <= '0;
      o_grant     <= '0;
      o_busy      <= 1'b0;
      o_drop_evt  <= 1'b0;
    end else begin
      o_req_endp <= '0;
      o_drop_evt <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            owner   <= win_idx;
            o_grant <= NUM_REQ'(1) << win_idx;
            o_busy  <= 1'b1;
            state   <= S_LATCH;
          end
        end
        S_LATCH: begin
          o_ddr_wxr   <= i_req_wxr[owner];
          o_ddr_area  <= area_arr[owner];
          o_ddr_addr  <= addr_arr[owner];
          o_ddr_size  <= size_arr[owner];
          o_ddr_start <= 1'b1;
          drop_q      <= 1'b0;
          state       <= S_ISSUE;
        end
        S_ISSUE: begin
          // A requester that gave up keeps the DDR access running but gets no end pulse.
          if (!i_req_start[owner]) drop_q <= 1'b1;
          if (i_ddr_endp) begin
            o_ddr_start <= 1'b0;
            state       <= S_DONE;
            if (drop_q || !i_req_start[owner]) o_drop_evt <= 1'b1;
            else                               o_req_endp <= o_grant;
          end else if (tmo_hit) begin
            o_ddr_start <= 1'b0;
            state       <= S_DONE;
            o_req_endp  <= o_grant;
            o_drop_evt  <= 1'b1;
          end
        end
        S_DONE: begin
          last_grant <= owner;
          o_grant    <= '0;
          state      <= S_GAP;
        end
        S_GAP: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sp_if_ddr_arb.sv
// Bench for sp_if_ddr_arb: acts as all requesters and as the DDR controller.
// Expected commands and completions come from a queue-based round-robin model.
`timescale 1ns/100ps
module tb_sp_if_ddr_arb;

  localparam int          N   = 4;
  localparam logic [31:0] TMO = 32'd100;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    r_start;
  logic [N-1:0]    r_wxr;
  logic [3:0]      r_area [N];
  logic [26:0]     r_addr [N];
  logic [31:0]     r_size [N];
  logic [4*N-1:0]  i_req_area;
  logic [27*N-1:0] i_req_addr;
  logic [32*N-1:0] i_req_size;
  logic            i_ddr_endp;
  logic            o_ddr_wxr;
  logic [3:0]      o_ddr_area;
  logic [26:0]     o_ddr_addr;
  logic [31:0]     o_ddr_size;
  logic            o_ddr_start;
  logic [N-1:0]    o_req_endp;
  logic [N-1:0]    o_grant;
  logic            o_busy;
  logic            o_drop_evt;
  logic [2:0]      o_state;

  int checks = 0;
  int errors = 0;
  int m_last = N - 1;
  int rem [N];
  logic [N-1:0] reraise;
  bit endp_pend;

  // cmd = {grant, wxr, area, addr, size}; end = {drop_evt, req_endp}
  logic [67:0]  exp_cmd_q [$];
  logic [N:0]   exp_end_q [$];

  sp_if_ddr_arb #(.NUM_REQ(N), .TIMEOUT_CYC(TMO)) dut (
    .i_clk156m  (clk),
    .i_arst_n   (rst_n),
    .i_req_start(r_start),
    .i_req_wxr  (r_wxr),
    .i_req_area (i_req_area),
    .i_req_addr (i_req_addr),
    .i_req_size (i_req_size),
    .i_ddr_endp (i_ddr_endp),
    .o_ddr_wxr  (o_ddr_wxr),
    .o_ddr_area (o_ddr_area),
    .o_ddr_addr (o_ddr_addr),
    .o_ddr_size (o_ddr_size),
    .o_ddr_start(o_ddr_start),
    .o_req_endp (o_req_endp),
    .o_grant    (o_grant),
    .o_busy     (o_busy),
    .o_drop_evt (o_drop_evt),
    .o_state    (o_state)
  );

  // clock / reset
  initial forever #3.2 clk = ~clk;

  always_comb begin
    for (int r = 0; r < N; r++) begin
      i_req_area[r*4 +: 4]   = r_area[r];
      i_req_addr[r*27 +: 27] = r_addr[r];
      i_req_size[r*32 +: 32] = r_size[r];
    end
  end

  function automatic logic [N-1:0] onehot(input int r);
    logic [N-1:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  function automatic logic [67:0] cmd_of(input int r);
    return {onehot(r), r_wxr[r], r_area[r], r_addr[r], r_size[r]};
  endfunction

  // Reference model: serve every outstanding access in round-robin order from m_last+1.
  task automatic model_round();
    int cnt [N];
    int total;
    int idx;
    bit found;
    total = 0;
    for (int r = 0; r < N; r++) begin
      cnt[r] = (r_start[r] ? 1 : 0) + rem[r];
      total += cnt[r];
    end
    for (int k = 0; k < total; k++) begin
      found = 1'b0;
      idx = 0;
      for (int j = 1; j <= N; j++) begin
        if (!found && cnt[(m_last + j) % N] > 0) begin
          idx = (m_last + j) % N;
          found = 1'b1;
        end
      end
      exp_cmd_q.push_back(cmd_of(idx));
      exp_end_q.push_back({1'b0, onehot(idx)});
      cnt[idx]--;
      m_last = idx;
    end
  endtask

  task automatic rand_fields(input int r);
    r_wxr[r]  = 1'($urandom_range(0, 1));
    r_area[r] = 4'($urandom_range(0, 15));
    r_addr[r] = 27'($urandom);
    r_size[r] = $urandom;
  endtask

  task automatic check_all_zero(input string name);
    logic [74:0] act;
    act = {o_ddr_start, o_ddr_wxr, o_ddr_area, o_ddr_addr, o_ddr_size,
           o_req_endp, o_grant, o_busy, o_drop_evt};
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL %s: outputs=%h required 0", name, act);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (!o_ddr_start && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_bit("wait_ddr_start", o_ddr_start, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (o_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_bit("wait_idle", o_busy, 1'b0);
  endtask

  // Requesters drop start on their end pulse and optionally re-raise one clock later;
  // the DDR controller answers o_ddr_start after a random delay.
  task automatic run_round(input int budget);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      i_ddr_endp = 1'b0;
      for (int r = 0; r < N; r++) begin
        if (o_req_endp[r]) begin
          r_start[r] = 1'b0;
          if (rem[r] > 0) begin
            rem[r]--;
            reraise[r] = 1'b1;
          end
        end else if (reraise[r]) begin
          r_start[r] = 1'b1;
          reraise[r] = 1'b0;
        end
      end
      if (!o_ddr_start) endp_pend = 1'b0;
      else if (!endp_pend && $urandom_range(0, 3) == 0) begin
        i_ddr_endp = 1'b1;
        endp_pend  = 1'b1;
      end
      done = (r_start == '0) && (reraise == '0) && !o_busy &&
             (exp_cmd_q.size() == 0) && (exp_end_q.size() == 0);
    end
    i_ddr_endp = 1'b0;
    check_bit("round_complete", done, 1'b1);
  endtask

  // Monitor / scoreboard
  initial begin
    logic        prev_start;
    logic        prev_done;
    logic [67:0] exp_c, act_c;
    logic [N:0]  exp_e, act_e;
    prev_start = 1'b0;
    prev_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_start = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (prev_done) begin
          checks++;
          if (o_grant !== '0) begin
            errors++;
            $display("FAIL gap_grant: o_grant=%b required 0", o_grant);
          end
        end
        if (o_ddr_start && !prev_start) begin
          checks++;
          act_c = {o_grant, o_ddr_wxr, o_ddr_area, o_ddr_addr, o_ddr_size};
          if (exp_cmd_q.size() == 0) begin
            errors++;
            $display("FAIL cmd_unexpected: got %h with nothing expected", act_c);
          end else begin
            exp_c = exp_cmd_q.pop_front();
            if (act_c !== exp_c) begin
              errors++;
              $display("FAIL cmd: got %h required %h", act_c, exp_c);
            end
          end
        end
        if (o_req_endp != '0 || o_drop_evt) begin
          checks++;
          act_e = {o_drop_evt, o_req_endp};
          if (exp_end_q.size() == 0) begin
            errors++;
            $display("FAIL end_unexpected: got %b with nothing expected", act_e);
          end else begin
            exp_e = exp_end_q.pop_front();
            if (act_e !== exp_e) begin
              errors++;
              $display("FAIL end: got %b required %b", act_e, exp_e);
            end
          end
        end
        prev_start = o_ddr_start;
        prev_done  = (o_req_endp != '0) || o_drop_evt;
      end
    end
  end

  // Stimulus
  initial begin
    logic [26:0] saved_addr;
    int n;
    r_start    = '0;
    r_wxr      = '0;
    reraise    = '0;
    i_ddr_endp = 1'b0;
    endp_pend  = 1'b0;
    for (int r = 0; r < N; r++) begin
      rem[r] = 0;
      rand_fields(r);
    end
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);

    // Contention: everyone requests, requester 0 comes back once -> 0,1,2,3,0
    for (int r = 0; r < N; r++) begin
      rand_fields(r);
      r_start[r] = 1'b1;
    end
    rem[0] = 1;
    model_round();
    run_round(1000);

    // Single request with fixed fields and latency checks
    r_wxr[2]  = 1'b1;
    r_addr[2] = 27'h0001000;
    r_size[2] = 32'h400;
    r_start[2] = 1'b1;
    model_round();
    @(negedge clk);
    checks++;
    if (o_grant !== 4'b0100) begin
      errors++;
      $display("FAIL grant_t1: o_grant=%b required 0100", o_grant);
    end
    check_bit("start_low_t1", o_ddr_start, 1'b0);
    @(negedge clk);
    check_bit("start_high_t2", o_ddr_start, 1'b1);
    run_round(200);

    // Owner 1 drops its start mid-ISSUE
    rand_fields(1);
    exp_cmd_q.push_back(cmd_of(1));
    exp_end_q.push_back({1'b1, {N{1'b0}}});
    m_last = 1;
    r_start[1] = 1'b1;
    wait_start(20);
    repeat (2) @(negedge clk);
    r_start[1] = 1'b0;
    repeat (3) @(negedge clk);
    check_bit("start_hold_after_drop", o_ddr_start, 1'b1);
    i_ddr_endp = 1'b1;
    @(negedge clk);
    i_ddr_endp = 1'b0;
    wait_idle(20);
    @(negedge clk);
    check_bit("drop_consumed", exp_end_q.size() == 0, 1'b1);

    // Stray completion while idle
    saved_addr = o_ddr_addr;
    i_ddr_endp = 1'b1;
    @(negedge clk);
    i_ddr_endp = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_busy, o_grant, o_ddr_start, o_req_endp, o_drop_evt} !== '0 || o_ddr_addr !== saved_addr) begin
      errors++;
      $display("FAIL stray_endp: busy=%b grant=%b start=%b addr=%h required idle, addr %h",
               o_busy, o_grant, o_ddr_start, o_ddr_addr, saved_addr);
    end

    // No completion from the DDR side
    rand_fields(3);
    exp_cmd_q.push_back(cmd_of(3));
    m_last = 3;
    r_start[3] = 1'b1;
    wait_start(20);
`ifdef SP_IF_DDR_ARB_TIMEOUT_EN
    exp_end_q.push_back({1'b1, onehot(3)});
    n = 0;
    while (o_req_endp == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 100) begin
      errors++;
      $display("FAIL timeout_latency: %0d clocks required 100", n);
    end
    r_start[3] = 1'b0;
`else
    exp_end_q.push_back({1'b0, onehot(3)});
    n = 0;
    repeat (150) @(negedge clk);
    check_bit("no_timeout_hold", o_ddr_start && (o_req_endp == '0), 1'b1);
    i_ddr_endp = 1'b1;
    @(negedge clk);
    i_ddr_endp = 1'b0;
    @(negedge clk);
    r_start[3] = 1'b0;
`endif
    wait_idle(20);

    // Reset during ISSUE abandons the access and restarts arbitration at 0
    rand_fields(2);
    exp_cmd_q.push_back(cmd_of(2));
    r_start[2] = 1'b1;
    wait_start(20);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_in_issue");
    exp_end_q.delete();
    m_last = N - 1;
    @(negedge clk);
    rst_n = 1'b1;
    rand_fields(0);
    r_start[0] = 1'b1;
    model_round();
    run_round(200);

    // Random rounds
    for (int k = 0; k < 25; k++) begin
      logic [N-1:0] mask;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int r = 0; r < N; r++) begin
        if (mask[r]) begin
          rand_fields(r);
          rem[r] = $urandom_range(0, 2);
          r_start[r] = 1'b1;
        end
      end
      model_round();
      run_round(1000);
    end

    repeat (3) @(negedge clk);
    check_bit("queues_empty", (exp_cmd_q.size() == 0) && (exp_end_q.size() == 0), 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
